data_io_wide: RTL and testbench

Parametrised ARM-to-FPGA download receiver for the MiST-style IO controller link, sitting between the SPI pins and the core's ROM/RAM loader. It oversamples the SPI bus in the `clk_sys` domain and decodes the file-transfer commands on `SPI_SS2` and raw SD-sector data on `SPI_SS4`. Bytes are packed into `DW`-bit little-endian words and buffered in a FIFO with a valid/ready handshake, so a loader that stalls does not lose data within the FIFO depth. It replaces toggle-strobe downloading with level handshaking, byte enables for partial final words, and a sticky overflow flag.

---
 rtl/data_io_pkg.sv | 15 +
 rtl/data_io_fifo.sv | 42 ++++
 rtl/data_io_wide.sv | 238 +++++++++++++++++++++++
 tb/tb_data_io_wide.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_io_pkg.sv
// Shared constants and FSM state type for the data_io download receiver.
// Command codes match the IO controller's file-transfer protocol.
package data_io_pkg;

  localparam logic [7:0] FILE_TX     = 8'h53;
  localparam logic [7:0] FILE_TX_DAT = 8'h54;
  localparam logic [7:0] FILE_INDEX  = 8'h55;

  typedef enum logic [1:0] {
    IDLE,
    DOWNLOAD,
    DRAIN
  } state_t;

endpackage

// File: rtl/data_io_fifo.sv
// Synchronous word FIFO with full/empty flags; head is read combinationally.
// The caller only writes when not full (or popping) and reads when not empty.
module data_io_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] wdata,
  input  logic         re,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wp;
  logic [PW:0]  rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (we) wp <= wp + 1'b1;
      if (re) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wp[PW-1:0]] <= wdata;
  end

  assign rdata = mem[rp[PW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) &&
                 (wp[PW-1:0] == rp[PW-1:0]);

endmodule

// File: rtl/data_io_wide.sv
// SPI download receiver packing bytes into DW-bit words behind a FIFO.
// Optional build macro DATA_IO_CHECKSUM_EN adds an XOR checksum of popped words.
module data_io_wide
  import data_io_pkg::*;
#(
  parameter int DW           = 16,
  parameter int AW           = 25,
  parameter int FIFO_DEPTH   = 8,
  parameter int SECTOR_BYTES = 512
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            SPI_SCK,
  input  logic            SPI_SS2,
  input  logic            SPI_SS4,
  input  logic            SPI_DI,
  input  logic            SPI_DO,
  output logic            ioctl_download,
  output logic            ioctl_verify,
  output logic [7:0]      ioctl_index,
  output logic            ioctl_wr,
  input  logic            ioctl_ready,
  output logic [AW-1:0]   ioctl_addr,
  output logic [DW-1:0]   ioctl_dout,
  output logic [DW/8-1:0] ioctl_be,
  output logic            ioctl_overflow,
  output logic [DW-1:0]   ioctl_checksum
);

  localparam int NB = DW / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;
  localparam int FW = AW + DW + NB;
  localparam int SW = $clog2(SECTOR_BYTES + 2);

  logic unused_pins;
  assign unused_pins = SPI_DO;

  logic [2:0] sck_p;
  logic [1:0] ss2_p;
  logic [2:0] ss4_p;
  logic [1:0] di_p;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sck_p <= '0;
      ss2_p <= '1;
      ss4_p <= '1;
      di_p  <= '0;
    end else begin
      sck_p <= {sck_p[1:0], SPI_SCK};
      ss2_p <= {ss2_p[0], SPI_SS2};
      ss4_p <= {ss4_p[1:0], SPI_SS4};
      di_p  <= {di_p[0], SPI_DI};
    end
  end

  logic sck_rise, ss2, ss4, ss4_rise, di;
  assign sck_rise = sck_p[1] & ~sck_p[2];
  assign ss2      = ss2_p[1];
  assign ss4      = ss4_p[1];
  assign ss4_rise = ss4_p[1] & ~ss4_p[2];
  assign di       = di_p[1];

  logic [7:0]    sr, rx, cmd;
  logic [2:0]    bc2, bc4, bcnt;
  logic          stb2, stb4;
  logic [SW-1:0] sec;

  // SS2 owns the shared shifter whenever it is selected
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sr   <= '0;
      rx   <= '0;
      bc2  <= '0;
      bc4  <= '0;
      stb2 <= 1'b0;
      stb4 <= 1'b0;
    end else begin
      stb2 <= 1'b0;
      stb4 <= 1'b0;
      if (ss2) bc2 <= '0;
      if (ss4) bc4 <= '0;
      if (sck_rise && !ss2) begin
        sr  <= {sr[6:0], di};
        bc2 <= bc2 + 1'b1;
        if (bc2 == 3'd7) begin
          rx   <= {sr[6:0], di};
          stb2 <= 1'b1;
        end
      end else if (sck_rise && !ss4) begin
        sr  <= {sr[6:0], di};
        bc4 <= bc4 + 1'b1;
        if (bc4 == 3'd7) begin
          rx   <= {sr[6:0], di};
          stb4 <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bcnt <= '0;
      cmd  <= '0;
      sec  <= '0;
    end else begin
      if (ss2) bcnt <= '0;
      else if (stb2 && bcnt != 3'd7) bcnt <= bcnt + 1'b1;
      if (stb2 && bcnt == 3'd0) cmd <= rx;
      if (ss4_rise) sec <= '0;
      else if (stb4)
        sec <= (sec == SW'(SECTOR_BYTES + 1)) ? '0 : sec + 1'b1;
    end
  end

  logic payload, start, stop, dat, idx;
  assign payload = stb2 && (bcnt != 3'd0);
  assign start   = payload && cmd == FILE_TX && rx != 8'd0;
  assign stop    = payload && cmd == FILE_TX && rx == 8'd0;
  assign idx     = payload && cmd == FILE_INDEX;
  assign dat     = (payload && cmd == FILE_TX_DAT) ||
                   (stb4 && sec < SW'(SECTOR_BYTES));

  logic [DW-1:0] wbuf, wbuf_n, pword;
  logic [LW-1:0] lane, lane_n;
  logic [AW-1:0] addr, addr_n;
  logic [NB-1:0] pbe;
  logic          push;

  always_comb begin
    wbuf_n = wbuf;
    lane_n = lane;
    addr_n = addr;
    pword  = wbuf;
    pbe    = '0;
    push   = 1'b0;
    if (start) begin
      wbuf_n = '0;
      lane_n = '0;
      addr_n = '0;
    end else if (dat) begin
      pword[8*int'(lane) +: 8] = rx;
      if (lane == LW'(NB - 1)) begin
        push   = 1'b1;
        pbe    = '1;
        wbuf_n = '0;
        lane_n = '0;
        addr_n = addr + AW'(NB);
      end else begin
        wbuf_n = pword;
        lane_n = lane + 1'b1;
      end
    end else if (stop && lane != '0) begin
      push = 1'b1;
      for (int i = 0; i < NB; i++) pbe[i] = (i < int'(lane));
      wbuf_n = '0;
      lane_n = '0;
      addr_n = addr + AW'(NB);
    end
  end

  logic          full, empty, pop, fifo_we;
  logic [FW-1:0] head;

  assign pop     = ~empty & ioctl_ready;
  assign fifo_we = push & (~full | pop);

  data_io_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .we    (fifo_we),
    .wdata ({addr, pword, pbe}),
    .re    (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  state_t state, state_n;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (start) state_n = DOWNLOAD;
      DOWNLOAD: if (stop) state_n = DRAIN;
      DRAIN: begin
        if (start) state_n = DOWNLOAD;
        else if (empty) state_n = IDLE;
      end
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      wbuf           <= '0;
      lane           <= '0;
      addr           <= '0;
      ioctl_verify   <= 1'b0;
      ioctl_index    <= '0;
      ioctl_overflow <= 1'b0;
    end else begin
      state <= state_n;
      wbuf  <= wbuf_n;
      lane  <= lane_n;
      addr  <= addr_n;
      if (start) ioctl_verify <= rx[1];
      if (idx) ioctl_index <= rx;
      if (start) ioctl_overflow <= 1'b0;
      else if (push && full && !pop) ioctl_overflow <= 1'b1;
    end
  end

  assign ioctl_download = (state != IDLE);
  assign ioctl_wr       = ~empty;
  assign {ioctl_addr, ioctl_dout, ioctl_be} = empty ? '0 : head;

`ifdef DATA_IO_CHECKSUM_EN
  logic [DW-1:0] mask, csum;

  always_comb begin
    mask = '0;
    for (int i = 0; i < DW; i++) mask[i] = ioctl_be[i/8];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) csum <= '0;
    else if (start) csum <= '0;
    else if (pop) csum <= csum ^ (ioctl_dout & mask);
  end

  assign ioctl_checksum = csum;
`else
  assign ioctl_checksum = '0;
`endif

endmodule

// File: tb/tb_data_io_wide.sv
// Directed bench for data_io_wide: a DW=16/depth-8 and a DW=32/depth-4
// instance share the SPI pins; popped words are collected per instance.
module tb_data_io_wide;
  import data_io_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0;
  logic sck = 1'b0, ss2 = 1'b1, ss4 = 1'b1, di = 1'b0, dpin = 1'b0;
  logic rdy16 = 1'b0, rdy32 = 1'b0;

  logic dl16, vf16, wr16, ov16;
  logic [7:0] ix16;
  logic [24:0] addr16;
  logic [15:0] dout16, cs16;
  logic [1:0] be16;
  logic dl32, vf32, wr32, ov32;
  logic [7:0] ix32;
  logic [24:0] addr32;
  logic [31:0] dout32, cs32;
  logic [3:0] be32;

  always #5 clk = ~clk;

  data_io_wide #(.DW(16), .FIFO_DEPTH(8)) u16 (
    .clk_sys(clk), .reset_n(rst_n),
    .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_SS4(ss4),
    .SPI_DI(di), .SPI_DO(dpin),
    .ioctl_download(dl16), .ioctl_verify(vf16),
    .ioctl_index(ix16), .ioctl_wr(wr16),
    .ioctl_ready(rdy16), .ioctl_addr(addr16),
    .ioctl_dout(dout16), .ioctl_be(be16),
    .ioctl_overflow(ov16), .ioctl_checksum(cs16)
  );

  data_io_wide #(.DW(32), .FIFO_DEPTH(4)) u32 (
    .clk_sys(clk), .reset_n(rst_n),
    .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_SS4(ss4),
    .SPI_DI(di), .SPI_DO(dpin),
    .ioctl_download(dl32), .ioctl_verify(vf32),
    .ioctl_index(ix32), .ioctl_wr(wr32),
    .ioctl_ready(rdy32), .ioctl_addr(addr32),
    .ioctl_dout(dout32), .ioctl_be(be32),
    .ioctl_overflow(ov32), .ioctl_checksum(cs32)
  );

  typedef struct {
    logic [24:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wd_t;

  wd_t q16[$];
  wd_t q32[$];

  always @(negedge clk) begin
    if (wr16 && rdy16) q16.push_back('{addr16, {16'h0, dout16}, {2'b0, be16}});
    if (wr32 && rdy32) q32.push_back('{addr32, dout32, be32});
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic take16(output wd_t w);
    int n;
    n = 0;
    while (q16.size() == 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q16.size() > 0) w = q16.pop_front();
    else begin
      w.a = '1; w.d = '1; w.be = '1;
    end
  endtask

  task automatic take32(output wd_t w);
    int n;
    n = 0;
    while (q32.size() == 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q32.size() > 0) w = q32.pop_front();
    else begin
      w.a = '1; w.d = '1; w.be = '1;
    end
  endtask

  task automatic chkw(input string tag, input wd_t w, input logic [24:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    chk(tag, {3'b0, w.a, w.d, w.be}, {3'b0, a, d, be});
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      di = b[i];
      repeat (4) @(posedge clk);
      #1 sck = 1'b1;
      repeat (4) @(posedge clk);
      #1 sck = 1'b0;
    end
  endtask

  task automatic sel2();
    #1 ss2 = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic desel2();
    repeat (8) @(posedge clk);
    #1 ss2 = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic cmd(input logic [7:0] c, input logic [7:0] b);
    sel2();
    spi_byte(c);
    spi_byte(b);
    desel2();
  endtask

  wd_t w;
  int sz, bad;

  initial begin
    repeat (3) @(posedge clk);
    chk("rst_ctl16", {dl16, vf16, ix16, wr16, ov16, cs16}, '0);
    chk("rst_dat16", {addr16, dout16, be16}, '0);
    chk("rst_all32", {dl32, vf32, ix32, wr32, ov32, addr32, be32}, '0);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    chk("rst_rel", {wr16, wr32, dl16, dl32, dout32}, '0);

    rdy16 = 1'b1; rdy32 = 1'b1;
    cmd(FILE_TX, 8'h01);
    chk("dl_on", {dl16, dl32, vf16}, 3'b110);
    sel2();
    spi_byte(FILE_TX_DAT);
    spi_byte(8'hAA); spi_byte(8'hBB); spi_byte(8'hCC); spi_byte(8'hDD);
    desel2();
    cmd(FILE_TX, 8'h00);
    repeat (20) @(posedge clk);
    take16(w); chkw("t1_w0_16", w, 0, 32'hBBAA, 4'h3);
    take16(w); chkw("t1_w1_16", w, 2, 32'hDDCC, 4'h3);
    take32(w); chkw("t1_w0_32", w, 0, 32'hDDCCBBAA, 4'hF);
    chk("t1_dl_off", {dl16, dl32}, 2'b00);
    chk("t1_no_extra", {32'(q16.size()), 32'(q32.size())}, '0);

    cmd(FILE_TX, 8'h01);
    sel2();
    spi_byte(FILE_TX_DAT);
    for (int i = 1; i <= 5; i++) spi_byte(8'(i));
    desel2();
    cmd(FILE_TX, 8'h00);
    repeat (20) @(posedge clk);
    take32(w); chkw("t2_w0_32", w, 0, 32'h04030201, 4'hF);
    take32(w); chkw("t2_w1_32", w, 4, 32'h00000005, 4'h1);
    take16(w); chkw("t2_w0_16", w, 0, 32'h0201, 4'h3);
    take16(w); chkw("t2_w1_16", w, 2, 32'h0403, 4'h3);
    take16(w); chkw("t2_w2_16", w, 4, 32'h0005, 4'h1);

    cmd(FILE_INDEX, 8'h07);
    chk("index", {ix16, ix32}, 16'h0707);
    cmd(FILE_TX, 8'h03);
    chk("verify", {vf16, vf32, dl16}, 3'b111);
    cmd(FILE_TX, 8'h00);
    repeat (20) @(posedge clk);
    chk("t3_dl_off", {dl16, dl32}, 2'b00);

    #1 ss4 = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 514; i++) spi_byte(8'(i));
    repeat (8) @(posedge clk);
    #1 ss4 = 1'b1;
    repeat (20) @(posedge clk);
    sz = q16.size();
    chk("ss4_cnt16", 64'(sz), 64'd256);
    bad = 0;
    for (int k = 0; k < 256 && q16.size() > 0; k++) begin
      w = q16.pop_front();
      if ({w.a, w.d, w.be} !== {25'(2*k), 16'h0, 8'(2*k+1), 8'(2*k), 4'h3})
        bad++;
    end
    chk("ss4_words16", 64'(bad), 64'd0);
    sz = q32.size();
    chk("ss4_cnt32", 64'(sz), 64'd128);
    bad = 0;
    for (int k = 0; k < 128 && q32.size() > 0; k++) begin
      w = q32.pop_front();
      if ({w.a, w.d, w.be} !== {25'(4*k), 8'(4*k+3), 8'(4*k+2),
                                 8'(4*k+1), 8'(4*k), 4'hF})
        bad++;
    end
    chk("ss4_words32", 64'(bad), 64'd0);
    #1 ss4 = 1'b0;
    repeat (4) @(posedge clk);
    spi_byte(8'hA0); spi_byte(8'hA1); spi_byte(8'hA2); spi_byte(8'hA3);
    repeat (8) @(posedge clk);
    #1 ss4 = 1'b1;
    repeat (20) @(posedge clk);
    take16(w); chkw("sec2_w0_16", w, 512, 32'hA1A0, 4'h3);
    take16(w); chkw("sec2_w1_16", w, 514, 32'hA3A2, 4'h3);
    take32(w); chkw("sec2_w0_32", w, 512, 32'hA3A2A1A0, 4'hF);

    rdy16 = 1'b0; rdy32 = 1'b0;
    cmd(FILE_TX, 8'h01);
    sel2();
    spi_byte(FILE_TX_DAT);
    for (int i = 0; i < 20; i++) spi_byte(8'h10 + 8'(i));
    desel2();
    repeat (10) @(posedge clk);
    chk("ovf_set", {ov16, ov32}, 2'b11);
    chk("ovf_head16", {addr16, dout16, be16, wr16}, {25'd0, 16'h1110, 2'b11, 1'b1});
    repeat (5) @(posedge clk);
    chk("ovf_hold16", {addr16, dout16, be16}, {25'd0, 16'h1110, 2'b11});
    chk("ovf_hold32", {addr32, dout32, be32}, {25'd0, 32'h13121110, 4'hF});
    #1 rdy16 = 1'b1; rdy32 = 1'b1;
    repeat (20) @(posedge clk);
    sz = q16.size();
    chk("ovf_cnt16", 64'(sz), 64'd8);
    bad = 0;
    for (int k = 0; k < 8 && q16.size() > 0; k++) begin
      w = q16.pop_front();
      if ({w.a, w.d} !== {25'(2*k), 16'h0, 8'h11 + 8'(2*k), 8'h10 + 8'(2*k)})
        bad++;
    end
    chk("ovf_words16", 64'(bad), 64'd0);
    sz = q32.size();
    chk("ovf_cnt32", 64'(sz), 64'd4);
    bad = 0;
    for (int k = 0; k < 4 && q32.size() > 0; k++) begin
      w = q32.pop_front();
      if (w.a !== 25'(4*k)) bad++;
    end
    chk("ovf_addr32", 64'(bad), 64'd0);
    sel2();
    spi_byte(FILE_TX_DAT);
    spi_byte(8'h30); spi_byte(8'h31); spi_byte(8'h32); spi_byte(8'h33);
    desel2();
    take16(w); chkw("ovf_adv16", w, 20, 32'h3130, 4'h3);
    take16(w); chkw("ovf_adv16b", w, 22, 32'h3332, 4'h3);
    take32(w); chkw("ovf_adv32", w, 20, 32'h33323130, 4'hF);
    chk("ovf_sticky", {ov16, ov32}, 2'b11);

    cmd(FILE_TX, 8'h01);
    chk("ovf_clear", {ov16, ov32}, 2'b00);
    sel2();
    spi_byte(FILE_TX_DAT);
    spi_byte(8'h77);
    for (int i = 0; i < 3; i++) begin
      di = 1'b1;
      repeat (4) @(posedge clk);
      #1 sck = 1'b1;
      repeat (4) @(posedge clk);
      #1 sck = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    chk("mid_rst16", {dl16, vf16, ix16, wr16, ov16, addr16, dout16, be16}, '0);
    chk("mid_rst32", {dl32, vf32, ix32, wr32, ov32, addr32, be32}, '0);
    ss2 = 1'b1; sck = 1'b0; di = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    cmd(FILE_TX, 8'h01);
    sel2();
    spi_byte(FILE_TX_DAT);
    spi_byte(8'h5A); spi_byte(8'hA5);
    desel2();
    cmd(FILE_TX, 8'h00);
    repeat (20) @(posedge clk);
    take16(w); chkw("rst_restart16", w, 0, 32'hA55A, 4'h3);
    take32(w); chkw("rst_restart32", w, 0, 32'h0000A55A, 4'h3);
    chk("checksum_off", {cs16, cs32}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
